// File: rtl/pipelined_control_unit.sv
// Registered MIPS control decoder for the ID/EX boundary: one-cycle latency, stall/flush,
// jump/link, load/store width and sign, and a HALT drain-then-freeze sequence.
module pipelined_control_unit #(
    parameter int NB_OPCODE    = 6,
    parameter int NB_FUNCT     = 6,
    parameter int NB_MEM_WIDTH = 2,
    parameter int N_DRAIN      = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic [NB_OPCODE-1:0]    i_opcode,
    input  logic [NB_FUNCT-1:0]     i_funct,
    output logic                    o_reg_dest,
    output logic                    o_alu_src,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic                    o_branch,
    output logic                    o_branch_ne,
    output logic                    o_jump,
    output logic                    o_jump_reg,
    output logic                    o_link,
    output logic                    o_reg_write,
    output logic                    o_mem_to_reg,
    output logic                    o_mem_unsigned,
    output logic [NB_OPCODE-1:0]    o_alu_op,
    output logic [NB_MEM_WIDTH-1:0] o_mem_width,
    output logic                    o_valid,
    output logic                    o_illegal,
    output logic                    o_halted
);

    localparam int NB_CNT = 4;

    localparam logic [NB_OPCODE-1:0] OP_RTYPE = NB_OPCODE'(6'h00);
    localparam logic [NB_OPCODE-1:0] OP_J     = NB_OPCODE'(6'h02);
    localparam logic [NB_OPCODE-1:0] OP_JAL   = NB_OPCODE'(6'h03);
    localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'(6'h04);
    localparam logic [NB_OPCODE-1:0] OP_BNE   = NB_OPCODE'(6'h05);
    localparam logic [NB_OPCODE-1:0] OP_ADDI  = NB_OPCODE'(6'h08);
    localparam logic [NB_OPCODE-1:0] OP_SLTI  = NB_OPCODE'(6'h0a);
    localparam logic [NB_OPCODE-1:0] OP_ANDI  = NB_OPCODE'(6'h0c);
    localparam logic [NB_OPCODE-1:0] OP_ORI   = NB_OPCODE'(6'h0d);
    localparam logic [NB_OPCODE-1:0] OP_XORI  = NB_OPCODE'(6'h0e);
    localparam logic [NB_OPCODE-1:0] OP_LUI   = NB_OPCODE'(6'h0f);
    localparam logic [NB_OPCODE-1:0] OP_LB    = NB_OPCODE'(6'h20);
    localparam logic [NB_OPCODE-1:0] OP_LH    = NB_OPCODE'(6'h21);
    localparam logic [NB_OPCODE-1:0] OP_LHU   = NB_OPCODE'(6'h22);
    localparam logic [NB_OPCODE-1:0] OP_LW    = NB_OPCODE'(6'h23);
    localparam logic [NB_OPCODE-1:0] OP_LWU   = NB_OPCODE'(6'h24);
    localparam logic [NB_OPCODE-1:0] OP_LBU   = NB_OPCODE'(6'h25);
    localparam logic [NB_OPCODE-1:0] OP_SB    = NB_OPCODE'(6'h28);
    localparam logic [NB_OPCODE-1:0] OP_SH    = NB_OPCODE'(6'h29);
    localparam logic [NB_OPCODE-1:0] OP_SW    = NB_OPCODE'(6'h2b);
    localparam logic [NB_OPCODE-1:0] OP_HALT  = NB_OPCODE'(6'h3f);

    localparam logic [NB_FUNCT-1:0] FN_JR   = NB_FUNCT'(6'h08);
    localparam logic [NB_FUNCT-1:0] FN_JALR = NB_FUNCT'(6'h09);

    localparam logic [NB_MEM_WIDTH-1:0] W_BYTE = NB_MEM_WIDTH'(2'b00);
    localparam logic [NB_MEM_WIDTH-1:0] W_HALF = NB_MEM_WIDTH'(2'b01);
    localparam logic [NB_MEM_WIDTH-1:0] W_WORD = NB_MEM_WIDTH'(2'b11);

    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_DRAIN - 1);

    typedef struct packed {
        logic                    reg_dest;
        logic                    alu_src;
        logic                    mem_read;
        logic                    mem_write;
        logic                    branch;
        logic                    branch_ne;
        logic                    jump;
        logic                    jump_reg;
        logic                    link;
        logic                    reg_write;
        logic                    mem_to_reg;
        logic                    mem_unsigned;
        logic [NB_OPCODE-1:0]    alu_op;
        logic [NB_MEM_WIDTH-1:0] mem_width;
        logic                    valid;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    ctrl_t              dec_s;
    logic               dec_illegal_s;
    logic               dec_halt_s;
    ctrl_t              ctrl_r;
    logic               illegal_r;
    logic               halted_r;
    state_t             state_r;
    logic [NB_CNT-1:0]  drain_cnt_r;

    // Combinational decode of the ID-stage instruction into a candidate control word
    always_comb begin
        dec_s         = BUBBLE;
        dec_s.valid   = 1'b1;
        dec_illegal_s = 1'b0;
        dec_halt_s    = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                dec_s.reg_dest  = 1'b1;
                dec_s.reg_write = 1'b1;
                case (i_funct)
                    FN_JR: begin
                        dec_s.jump      = 1'b1;
                        dec_s.jump_reg  = 1'b1;
                        dec_s.reg_write = 1'b0;
                    end
                    FN_JALR: begin
                        dec_s.jump     = 1'b1;
                        dec_s.jump_reg = 1'b1;
                        dec_s.link     = 1'b1;
                    end
                    default: begin
                        dec_s.jump = 1'b0;
                    end
                endcase
            end
            OP_J: begin
                dec_s.jump = 1'b1;
            end
            OP_JAL: begin
                dec_s.jump      = 1'b1;
                dec_s.link      = 1'b1;
                dec_s.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_s.branch    = 1'b1;
                dec_s.branch_ne = (i_opcode == OP_BNE);
                dec_s.alu_op    = i_opcode;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = i_opcode;
            end
            OP_LB, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LBU: begin
                dec_s.mem_read   = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.alu_op     = OP_ADDI;
                dec_s.mem_unsigned = (i_opcode == OP_LBU) || (i_opcode == OP_LHU) ||
                                     (i_opcode == OP_LWU);
                if ((i_opcode == OP_LB) || (i_opcode == OP_LBU)) begin
                    dec_s.mem_width = W_BYTE;
                end else if ((i_opcode == OP_LH) || (i_opcode == OP_LHU)) begin
                    dec_s.mem_width = W_HALF;
                end else begin
                    dec_s.mem_width = W_WORD;
                end
            end
            OP_SB, OP_SH, OP_SW: begin
                dec_s.mem_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.alu_op    = OP_ADDI;
                if (i_opcode == OP_SB) begin
                    dec_s.mem_width = W_BYTE;
                end else if (i_opcode == OP_SH) begin
                    dec_s.mem_width = W_HALF;
                end else begin
                    dec_s.mem_width = W_WORD;
                end
            end
            OP_HALT: begin
                dec_s      = BUBBLE;
                dec_halt_s = 1'b1;
            end
            default: begin
                dec_s         = BUBBLE;
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Pipeline register and RUN/DRAIN/HALTED sequencing; flush beats hold, hold beats decode
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ctrl_r      <= BUBBLE;
            illegal_r   <= 1'b0;
            halted_r    <= 1'b0;
            state_r     <= ST_RUN;
            drain_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (i_flush) begin
                        ctrl_r    <= BUBBLE;
                        illegal_r <= 1'b0;
                    end else if (i_stall || !i_enable) begin
                        illegal_r <= 1'b0;
                    end else begin
                        ctrl_r    <= dec_s;
                        illegal_r <= dec_illegal_s;
                        if (dec_halt_s) begin
                            state_r     <= ST_DRAIN;
                            drain_cnt_r <= '0;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    ctrl_r    <= BUBBLE;
                    illegal_r <= 1'b0;
                    if (i_enable) begin
                        if (drain_cnt_r == CNT_LAST) begin
                            state_r  <= ST_HALTED;
                            halted_r <= 1'b1;
                        end else begin
                            drain_cnt_r <= drain_cnt_r + NB_CNT'(1);
                        end
                    end else begin
                        drain_cnt_r <= drain_cnt_r;
                    end
                end
                ST_HALTED: begin
                    ctrl_r    <= BUBBLE;
                    illegal_r <= 1'b0;
                    halted_r  <= 1'b1;
                end
                default: begin
                    ctrl_r      <= BUBBLE;
                    illegal_r   <= 1'b0;
                    halted_r    <= 1'b0;
                    state_r     <= ST_RUN;
                    drain_cnt_r <= '0;
                end
            endcase
        end
    end

    assign o_reg_dest     = ctrl_r.reg_dest;
    assign o_alu_src      = ctrl_r.alu_src;
    assign o_mem_read     = ctrl_r.mem_read;
    assign o_mem_write    = ctrl_r.mem_write;
    assign o_branch       = ctrl_r.branch;
    assign o_branch_ne    = ctrl_r.branch_ne;
    assign o_jump         = ctrl_r.jump;
    assign o_jump_reg     = ctrl_r.jump_reg;
    assign o_link         = ctrl_r.link;
    assign o_reg_write    = ctrl_r.reg_write;
    assign o_mem_to_reg   = ctrl_r.mem_to_reg;
    assign o_mem_unsigned = ctrl_r.mem_unsigned;
    assign o_alu_op       = ctrl_r.alu_op;
    assign o_mem_width    = ctrl_r.mem_width;
    assign o_valid        = ctrl_r.valid;
    assign o_illegal      = illegal_r;
    assign o_halted       = halted_r;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: a driver pushes expected control words from a table-driven reference
// model, a negedge monitor pops and compares them against the registered DUT outputs.
module tb_pipelined_control_unit;

    localparam int N_DRAIN = 4;

    typedef struct packed {
        logic       reg_dest;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jump_reg;
        logic       link;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_unsigned;
        logic [5:0] alu_op;
        logic [1:0] mem_width;
        logic       valid;
        logic       illegal;
        logic       halted;
    } ctl_t;

    typedef struct {
        ctl_t w;
        int   id;
    } exp_t;

    logic       clk;
    logic       rst, en, stall, flush;
    logic [5:0] opcode, funct;
    logic       reg_dest, alu_src, mem_read, mem_write, branch, branch_ne;
    logic       jump, jump_reg, link, reg_write, mem_to_reg, mem_unsigned;
    logic [5:0] alu_op;
    logic [1:0] mem_width;
    logic       valid, illegal, halted;

    pipelined_control_unit #(
        .NB_OPCODE(6), .NB_FUNCT(6), .NB_MEM_WIDTH(2), .N_DRAIN(N_DRAIN)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_flush(flush),
        .i_opcode(opcode), .i_funct(funct),
        .o_reg_dest(reg_dest), .o_alu_src(alu_src), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .o_branch(branch), .o_branch_ne(branch_ne),
        .o_jump(jump), .o_jump_reg(jump_reg), .o_link(link), .o_reg_write(reg_write),
        .o_mem_to_reg(mem_to_reg), .o_mem_unsigned(mem_unsigned), .o_alu_op(alu_op),
        .o_mem_width(mem_width), .o_valid(valid), .o_illegal(illegal), .o_halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables: index by (opcode - first opcode of the group)
    logic [1:0] load_w  [0:5] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
    logic       load_u  [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] store_w [0:3] = '{2'b00, 2'b01, 2'b00, 2'b11};
    logic [5:0] legal_ops [0:18] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c,
                                     6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h22, 6'h23,
                                     6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    ctl_t m_word;
    bit   m_ill, m_halted;
    int   m_mode;
    int   m_left;

    function automatic ctl_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                        output bit is_halt, output bit is_ill);
        ctl_t c;
        int   idx;
        c = '0;
        c.valid = 1'b1;
        is_halt = 1'b0;
        is_ill  = 1'b0;
        if (op == 6'h00) begin
            c.reg_dest  = 1'b1;
            c.reg_write = (fn != 6'h08);
            if (fn == 6'h08 || fn == 6'h09) begin
                c.jump = 1'b1;
                c.jump_reg = 1'b1;
                c.link = (fn == 6'h09);
            end
        end else if (op == 6'h02 || op == 6'h03) begin
            c.jump = 1'b1;
            c.link = (op == 6'h03);
            c.reg_write = (op == 6'h03);
        end else if (op == 6'h04 || op == 6'h05) begin
            c.branch = 1'b1;
            c.branch_ne = (op == 6'h05);
            c.alu_op = op;
        end else if (op inside {6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f}) begin
            c.alu_src = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op = op;
        end else if (op >= 6'h20 && op <= 6'h25) begin
            idx = int'(op) - 32;
            c.mem_read = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write = 1'b1;
            c.alu_src = 1'b1;
            c.alu_op = 6'h08;
            c.mem_width = load_w[idx];
            c.mem_unsigned = load_u[idx];
        end else if (op inside {6'h28, 6'h29, 6'h2b}) begin
            idx = int'(op) - 40;
            c.mem_write = 1'b1;
            c.alu_src = 1'b1;
            c.alu_op = 6'h08;
            c.mem_width = store_w[idx];
        end else if (op == 6'h3f) begin
            c = '0;
            is_halt = 1'b1;
        end else begin
            c = '0;
            is_ill = 1'b1;
        end
        return c;
    endfunction

    // One clock of stimulus: drive inputs off the edge, advance the model, queue its prediction
    task automatic step(input bit r, input bit e, input bit s, input bit f,
                        input logic [5:0] op, input logic [5:0] fn);
        ctl_t d;
        bit   h, il;
        exp_t x;
        @(negedge clk);
        #1;
        rst = r; en = e; stall = s; flush = f; opcode = op; funct = fn;
        if (r) begin
            m_word = '0; m_ill = 1'b0; m_halted = 1'b0; m_mode = 0; m_left = 0;
        end else if (m_mode == 0) begin
            m_ill = 1'b0;
            if (f) begin
                m_word = '0;
            end else if (!(s || !e)) begin
                d = ref_decode(op, fn, h, il);
                m_word = d;
                m_ill = il;
                if (h) begin
                    m_mode = 1;
                    m_left = N_DRAIN;
                end
            end
        end else if (m_mode == 1) begin
            m_word = '0; m_ill = 1'b0;
            if (e) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_halted = 1'b1;
                end
            end
        end else begin
            m_word = '0; m_ill = 1'b0; m_halted = 1'b1;
        end
        x.w = m_word;
        x.w.illegal = m_ill;
        x.w.halted = m_halted;
        x.id = step_id;
        exp_q.push_back(x);
        step_id++;
    endtask

    // Monitor: every settled output word is checked against the oldest queued prediction
    always @(negedge clk) begin
        exp_t e;
        ctl_t act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = '{reg_dest, alu_src, mem_read, mem_write, branch, branch_ne, jump, jump_reg,
                    link, reg_write, mem_to_reg, mem_unsigned, alu_op, mem_width, valid,
                    illegal, halted};
            n_cmp++;
            if (act !== e.w) begin
                n_fail++;
                $display("FAIL ctl_word step %0d: got %h required %h", e.id, act, e.w);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; stall = 1'b0; flush = 1'b0; opcode = 6'h00; funct = 6'h00;
        m_word = '0; m_ill = 1'b0; m_halted = 1'b0; m_mode = 0; m_left = 0;

        step(1, 1, 0, 0, 6'h00, 6'h00);
        step(1, 1, 0, 0, 6'h00, 6'h00);
        step(0, 1, 0, 0, 6'h23, 6'h00);

        // decode sweep
        step(0, 1, 0, 0, 6'h00, 6'h20);
        step(0, 1, 0, 0, 6'h00, 6'h08);
        step(0, 1, 0, 0, 6'h00, 6'h09);
        for (int i = 0; i < 19; i++) step(0, 1, 0, 0, legal_ops[i], 6'h00);

        // stall hold, release, then stall+flush
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 6'h08, 6'h00);
        step(0, 1, 0, 0, 6'h08, 6'h00);
        step(0, 1, 1, 1, 6'h0d, 6'h00);

        // illegal pulse, held illegal must not re-pulse
        step(0, 1, 0, 0, 6'h3e, 6'h00);
        step(0, 1, 1, 0, 6'h3e, 6'h00);
        step(0, 1, 1, 0, 6'h3e, 6'h00);
        step(0, 1, 0, 0, 6'h0d, 6'h00);

        // flushed HALT does not halt
        step(0, 1, 0, 1, 6'h3f, 6'h00);
        // HALT drain, later SW ignored
        step(0, 1, 0, 0, 6'h3f, 6'h00);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 6'h2b, 6'h00);

        // enable gaps stretch the drain
        step(1, 1, 0, 0, 6'h00, 6'h00);
        step(0, 1, 0, 0, 6'h3f, 6'h00);
        step(0, 1, 0, 0, 6'h00, 6'h00);
        step(0, 0, 0, 0, 6'h00, 6'h00);
        step(0, 0, 1, 1, 6'h00, 6'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 6'h23, 6'h00);

        // reset mid-drain at count 2
        step(1, 1, 0, 0, 6'h00, 6'h00);
        step(0, 1, 0, 0, 6'h3f, 6'h00);
        step(0, 1, 0, 0, 6'h00, 6'h00);
        step(0, 1, 0, 0, 6'h00, 6'h00);
        step(1, 1, 0, 0, 6'h00, 6'h00);
        step(0, 1, 0, 0, 6'h0d, 6'h00);
        step(0, 1, 0, 0, 6'h0d, 6'h00);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit         r, e, s, f;
            logic [5:0] op, fn;
            int         pick;
            r = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 6) == 0);
            f = ($urandom_range(0, 9) == 0);
            pick = $urandom_range(0, 99);
            if (pick < 60) op = legal_ops[$urandom_range(0, 18)];
            else if (pick < 75) op = 6'h00;
            else if (pick < 79) op = 6'h3f;
            else op = 6'($urandom_range(0, 63));
            pick = $urandom_range(0, 3);
            fn = (pick == 0) ? 6'h08 : (pick == 1) ? 6'h09 : 6'($urandom_range(0, 63));
            step(r, e, s, f, op, fn);
        end

        // let the monitor consume the tail, bounded
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Registered, parametrised successor to the combinational decoder of the MIPS pipeline. Decodes opcode and funct in ID and presents a one-cycle-latency control word to the ID/EX stage. It supports stall (hold), flush (bubble insertion), jumps and link, and load/store width and sign. A HALT state machine drains the pipeline and then freezes.

## Interface
- NB_OPCODE, 6: opcode width.
- NB_FUNCT, 6: funct width.
- NB_MEM_WIDTH, 2: memory access size code width.
- N_DRAIN, 4: bubble cycles emitted after HALT before o_halted (1..15).
- i_clock  in  1  clock; all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  1 = advance; 0 = hold all outputs and state.
- i_stall  in  1  hazard stall; hold outputs and state.
- i_flush  in  1  replace next control word with a bubble.
- i_opcode  in  NB_OPCODE  instruction[31:26].
- i_funct  in  NB_FUNCT  instruction[5:0].
- o_reg_dest, o_alu_src, o_mem_read, o_mem_write, o_branch, o_branch_ne, o_jump, o_jump_reg, o_link, o_reg_write, o_mem_to_reg, o_mem_unsigned  out  1 each  control flags.
- o_alu_op  out  NB_OPCODE  ALU operation selector.
- o_mem_width  out  NB_MEM_WIDTH  00 byte, 01 half, 11 word.
- o_valid  out  1  control word is a real instruction (0 = bubble).
- o_illegal  out  1  one-cycle pulse: unknown opcode/funct decoded.
- o_halted  out  1  pipeline drained after HALT; sticky until reset.

## Operation
- Bubble means all flags 0, o_alu_op 0, o_mem_width 00 and o_valid 0. Reset loads a bubble, sets o_illegal=0 and o_halted=0, sets the FSM to RUN and the drain counter to 0.
- In RUN, when updating, the registered word is decoded from i_opcode/i_funct. The decode table:
  - 0x00 R-type: reg_dest=1, reg_write=1, alu_op=0x00.
    - funct 0x08 JR: jump=1, jump_reg=1, reg_write=0.
    - funct 0x09 JALR: jump=1, jump_reg=1, link=1, reg_write=1.
  - 0x02 J: jump=1.
  - 0x03 JAL: jump=1, link=1, reg_write=1.
  - 0x04 BEQ: branch=1, alu_op=opcode. 0x05 BNE: branch=1, branch_ne=1, alu_op=opcode.
  - 0x08,0x0a,0x0c,0x0d,0x0e,0x0f (ADDI,SLTI,ANDI,ORI,XORI,LUI): alu_src=1, reg_write=1, alu_op=opcode.
  - Loads 0x20 LB, 0x21 LH, 0x22 LHU, 0x23 LW, 0x24 LWU, 0x25 LBU:
    - all set mem_read=1, mem_to_reg=1, reg_write=1, alu_src=1, alu_op=0x08.
    - width: byte for LB/LBU, half for LH/LHU, word for LW/LWU.
    - mem_unsigned=1 for LBU/LHU/LWU.
  - Stores 0x28 SB, 0x29 SH, 0x2b SW: mem_write=1, alu_src=1, alu_op=0x08, width byte/half/word.
  - 0x3f HALT: load a bubble and go to DRAIN with the counter at 0.
  - Any other opcode: bubble, o_illegal=1 for that cycle.
- o_valid=1 for every decoded entry except HALT and illegal.
- Update priority per edge: i_reset > i_flush > (i_stall or !i_enable) > decode.
  - flush: load a bubble; the opcode is discarded. A HALT presented with flush does not transition.
  - hold: all outputs keep their values, except o_illegal, which is 0; a HALT is not accepted.
- FSM:
  - RUN -> DRAIN on an accepted HALT.
  - DRAIN: outputs a bubble each cycle; the counter increments only while i_enable=1. At counter = N_DRAIN-1 with enable it goes to HALTED.
  - HALTED: o_halted=1 and outputs are a bubble. Exit only by reset.
  - In DRAIN and HALTED, i_opcode, i_stall and i_flush are ignored.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on outputs after edge k until the next update.
- o_illegal is high exactly one cycle per illegal opcode sampled in RUN under decode.
- The HALT accepted at edge k produces a bubble from edge k, and o_halted rises after edge k+N_DRAIN (with i_enable held at 1).
- A reset asserted in DRAIN or HALTED returns the block to the RUN/bubble state at the next edge. No partial state survives.

## Test plan
- Reset held 2 cycles, then release with LW (0x23): after the next edge, mem_read=1, mem_to_reg=1, reg_write=1, alu_src=1, alu_op=0x08, width=11, unsigned=0, valid=1. During reset, all outputs are 0.
- Sweep all 20 listed opcodes plus R-type funct 0x20, 0x08 and 0x09: each word matches the table one cycle later. LBU gives width=00 and unsigned=1; BNE gives branch_ne=1.
- Present ADDI with stall=1 for 3 cycles: the previous word holds. Then stall=0 gives the ADDI word. Stall and flush together produce a bubble with valid=0.
- Present opcode 0x3e: a bubble with o_illegal=1 for exactly one cycle. Holding 0x3e under stall produces no further pulse.
- HALT with N_DRAIN=4: bubbles follow, and o_halted=1 after the 4th edge. A later SW is ignored and o_halted stays 1. Deasserting i_enable mid-drain extends the drain by the number of disabled cycles.
- Reset asserted at drain count 2: next edge gives o_halted=0 and FSM RUN, and a following ORI decodes normally.
